// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with a registered link
// write port, optional write-to-read bypass and a per-register busy scoreboard.
// Register 0 is hardwired to zero and is never busy.
module regfile_mp #(
  parameter int W        = 32,
  parameter int AW       = 5,
  parameter int NR       = 2,
  parameter int LINK_REG = 31,
  parameter int BYPASS   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NR*AW-1:0] raddr,
  output logic [NR*W-1:0]  rdata,
  output logic [NR-1:0]    rbusy,
  input  logic             wen,
  input  logic [AW-1:0]    waddr,
  input  logic [W-1:0]     wdata,
  input  logic             link_en,
  input  logic [W-3:0]     link_pc,
  input  logic             mark_en,
  input  logic [AW-1:0]    mark_addr
);

  localparam int DEPTH = 2**AW;
  localparam logic [AW-1:0] LINK_A = AW'(LINK_REG);

  logic [W-1:0]     regs [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_nxt;
  logic [W-1:0]     link_val;
  logic             gen_we;
  logic             link_we;
  logic             mark_we;

  // Effective write/mark qualifiers; a general write to LINK_REG loses to the link port
  always_comb begin
    link_val = {link_pc, 2'b00};
    link_we  = link_en && !reset;
    gen_we   = wen && !reset && (waddr != '0) && !(link_en && (waddr == LINK_A));
    mark_we  = mark_en && !reset && (mark_addr != '0);
  end

  // Scoreboard update: writes retire a producer, a mark in the same cycle re-arms it
  always_comb begin
    busy_nxt = busy;
    if (gen_we)  busy_nxt[waddr]     = 1'b0;
    if (link_we) busy_nxt[LINK_A]    = 1'b0;
    if (mark_we) busy_nxt[mark_addr] = 1'b1;
  end

  // Storage and busy bits, cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      regs <= '{default: '0};
      busy <= '0;
    end else begin
      if (gen_we)  regs[waddr]  <= wdata;
      if (link_we) regs[LINK_A] <= link_val;
      busy <= busy_nxt;
    end
  end

  // Combinational read ports with optional forwarding of this cycle's write
  always_comb begin
    logic [AW-1:0] a;
    logic [W-1:0]  d;
    logic          b;
    logic          hit;
    rdata = '0;
    rbusy = '0;
    a     = '0;
    d     = '0;
    b     = 1'b0;
    hit   = 1'b0;
    for (int unsigned k = 0; k < NR; k++) begin
      a   = raddr[k*AW +: AW];
      d   = regs[a];
      b   = busy[a];
      hit = 1'b0;
      if (BYPASS != 0) begin
        if (link_we && (a == LINK_A)) begin
          d   = link_val;
          hit = 1'b1;
        end else if (gen_we && (a == waddr)) begin
          d   = wdata;
          hit = 1'b1;
        end
        if (hit && !(mark_we && (mark_addr == a))) b = 1'b0;
      end
      if (a == '0) begin
        d = '0;
        b = 1'b0;
      end
      rdata[k*W +: W] = d;
      rbusy[k]        = b;
    end
  end

endmodule
